// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU opcodes, Op/Funct values, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // ALU opcodes; the datapath ALU decodes exactly these values.
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_NOR = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_LUI = 4'b0111
    } alu_op_e;

    // Instruction[31:26] values handled by the controller.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction[5:0] values for the supported R-type operations.
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    // FSM state encodings; codes 12..15 are unreachable.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    // Full control word presented to the datapath each cycle.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       shift_src;
        logic       zero_ext;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_source;
    } ctrl_t;

    // Quiescent control word: every strobe and select low, ALU left on ADD.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle of the controller's instruction inputs and datapath control outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; master drives Op/Funct/Zero, slave (the controller) drives the control word.
interface multicycle_control_unit_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic [3:0] ALUOperation;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ShiftSrc;
    logic       ZeroExt;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       PCWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSource;
    logic       IllegalInstr;

    modport master (
        output Op, Funct, Zero,
        input  ALUOperation, ALUSrcA, ALUSrcB, ShiftSrc, ZeroExt, IorD,
               MemRead, MemWrite, IRWrite, RegWrite, PCWrite, RegDst,
               MemtoReg, PCSource, IllegalInstr
    );

    modport slave (
        input  Op, Funct, Zero,
        output ALUOperation, ALUSrcA, ALUSrcB, ShiftSrc, ZeroExt, IorD,
               MemRead, MemWrite, IRWrite, RegWrite, PCWrite, RegDst,
               MemtoReg, PCSource, IllegalInstr
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Maps Op/Funct to ALU opcode, shift routing, immediate extension and R-type legality.
// Latency: purely combinational.
// Backpressure: none.
module alu_op_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       shift_src_o,
    output logic       zero_ext_o,
    output logic       funct_ok_o
);

    // Opcode table; anything not listed leaves the ALU on ADD.
    always_comb begin
        alu_op_o    = ALU_ADD;
        shift_src_o = 1'b0;
        zero_ext_o  = 1'b0;
        funct_ok_o  = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                funct_ok_o = 1'b1;
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_NOR:  alu_op_o = ALU_NOR;
                    FN_SLL: begin
                        alu_op_o    = ALU_SLL;
                        shift_src_o = 1'b1;
                    end
                    FN_SRL: begin
                        alu_op_o    = ALU_SRL;
                        shift_src_o = 1'b1;
                    end
                    default: funct_ok_o = 1'b0;
                endcase
            end
            OP_ADDI: alu_op_o = ALU_ADD;
            OP_ANDI: begin
                alu_op_o   = ALU_AND;
                zero_ext_o = 1'b1;
            end
            OP_ORI: begin
                alu_op_o   = ALU_OR;
                zero_ext_o = 1'b1;
            end
            OP_LUI:  alu_op_o = ALU_LUI;
            default: alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: Moore FSM producing the datapath control word for each step.
// Latency: control word is registered with the state; only BRANCH PCWrite and DECODE IllegalInstr are combinational.
// Backpressure: none; one state per clock, reset forces FETCH and silences every strobe in the same cycle.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [3:0] ALUOperation,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ShiftSrc,
    output logic       ZeroExt,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic       IllegalInstr
);

    localparam logic [STATE_WIDTH-1:0] ST_FETCH  = STATE_WIDTH'(S_FETCH);
    localparam logic [STATE_WIDTH-1:0] ST_DECODE = STATE_WIDTH'(S_DECODE);
    localparam logic [STATE_WIDTH-1:0] ST_MEMADR = STATE_WIDTH'(S_MEMADR);
    localparam logic [STATE_WIDTH-1:0] ST_MEMRD  = STATE_WIDTH'(S_MEMRD);
    localparam logic [STATE_WIDTH-1:0] ST_MEMWB  = STATE_WIDTH'(S_MEMWB);
    localparam logic [STATE_WIDTH-1:0] ST_MEMWR  = STATE_WIDTH'(S_MEMWR);
    localparam logic [STATE_WIDTH-1:0] ST_EXEC_R = STATE_WIDTH'(S_EXEC_R);
    localparam logic [STATE_WIDTH-1:0] ST_RWB    = STATE_WIDTH'(S_RWB);
    localparam logic [STATE_WIDTH-1:0] ST_EXEC_I = STATE_WIDTH'(S_EXEC_I);
    localparam logic [STATE_WIDTH-1:0] ST_IWB    = STATE_WIDTH'(S_IWB);
    localparam logic [STATE_WIDTH-1:0] ST_BRANCH = STATE_WIDTH'(S_BRANCH);
    localparam logic [STATE_WIDTH-1:0] ST_JUMP   = STATE_WIDTH'(S_JUMP);

    logic [STATE_WIDTH-1:0] state_q, state_d;
    ctrl_t                  ctrl_q, ctrl_d, ctrl_out;
    logic [3:0]             dec_alu_op;
    logic                   dec_shift_src, dec_zero_ext, dec_funct_ok;
    logic                   decode_legal, state_valid, branch_taken;

    alu_op_decoder u_alu_op_decoder (
        .op_i        (Op),
        .funct_i     (Funct),
        .alu_op_o    (dec_alu_op),
        .shift_src_o (dec_shift_src),
        .zero_ext_o  (dec_zero_ext),
        .funct_ok_o  (dec_funct_ok)
    );

    // Control word for a given state. EXEC_R/EXEC_I take the decoder result, which
    // is captured on the DECODE->EXEC edge and held for the whole EXEC cycle.
    function automatic ctrl_t ctrl_for(input logic [STATE_WIDTH-1:0] st,
                                       input logic [3:0] alu_op,
                                       input logic shift_src,
                                       input logic zero_ext);
        ctrl_t c;
        c = ctrl_idle();
        case (st)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            ST_DECODE: c.alu_src_b = 2'b11;
            ST_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = alu_op;
                c.shift_src = shift_src;
            end
            ST_RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = alu_op;
                c.zero_ext  = zero_ext;
            end
            ST_IWB: c.reg_write = 1'b1;
            ST_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_source = 2'b01;
            end
            ST_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            default: c = ctrl_idle();
        endcase
        return c;
    endfunction

    // Is the current opcode (and funct, for R-type) one the controller executes?
    always_comb begin
        decode_legal = 1'b0;
        case (Op)
            OP_RTYPE: decode_legal = dec_funct_ok;
            OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
            OP_BEQ, OP_BNE, OP_J: decode_legal = 1'b1;
            default: decode_legal = 1'b0;
        endcase
    end

    // Next-state selection; Op/Funct only matter in DECODE and MEMADR.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (!decode_legal) begin
                    state_d = ST_FETCH;
                end else begin
                    case (Op)
                        OP_RTYPE:                         state_d = ST_EXEC_R;
                        OP_LW, OP_SW:                     state_d = ST_MEMADR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = ST_EXEC_I;
                        OP_BEQ, OP_BNE:                   state_d = ST_BRANCH;
                        OP_J:                             state_d = ST_JUMP;
                        default:                          state_d = ST_FETCH;
                    endcase
                end
            end
            ST_MEMADR: state_d = (Op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = ST_MEMWB;
            ST_EXEC_R: state_d = ST_RWB;
            ST_EXEC_I: state_d = ST_IWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Control word that accompanies the next state.
    always_comb begin
        ctrl_d = ctrl_for(state_d, dec_alu_op, dec_shift_src, dec_zero_ext);
    end

    // State register and registered control word, both forced to FETCH on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ctrl_q  <= ctrl_for(ST_FETCH, dec_alu_op, dec_shift_src, dec_zero_ext);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Flag encodings outside the twelve defined states so they drive nothing.
    always_comb begin
        state_valid = 1'b0;
        case (state_q)
            ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
            ST_EXEC_R, ST_RWB, ST_EXEC_I, ST_IWB, ST_BRANCH, ST_JUMP: state_valid = 1'b1;
            default: state_valid = 1'b0;
        endcase
    end

    // Silence the control word during reset or in a stray state; resolve branch direction.
    always_comb begin
        ctrl_out = ctrl_q;
        if (reset || !state_valid) begin
            ctrl_out = ctrl_idle();
        end
        branch_taken = (Op == OP_BNE) ? ~Zero : Zero;
    end

    assign ALUOperation = ctrl_out.alu_op;
    assign ALUSrcA      = ctrl_out.alu_src_a;
    assign ALUSrcB      = ctrl_out.alu_src_b;
    assign ShiftSrc     = ctrl_out.shift_src;
    assign ZeroExt      = ctrl_out.zero_ext;
    assign IorD         = ctrl_out.iord;
    assign MemRead      = ctrl_out.mem_read;
    assign MemWrite     = ctrl_out.mem_write;
    assign IRWrite      = ctrl_out.ir_write;
    assign RegWrite     = ctrl_out.reg_write;
    assign RegDst       = ctrl_out.reg_dst;
    assign MemtoReg     = ctrl_out.mem_to_reg;
    assign PCSource     = ctrl_out.pc_source;
    assign PCWrite      = ctrl_out.pc_write | (!reset && (state_q == ST_BRANCH) && branch_taken);
    assign IllegalInstr = !reset && (state_q == ST_DECODE) && !decode_legal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a randomized instruction stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_control_unit;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_unit_if bus();

    multicycle_control_unit #(.STATE_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .Op           (bus.Op),
        .Funct        (bus.Funct),
        .Zero         (bus.Zero),
        .ALUOperation (bus.ALUOperation),
        .ALUSrcA      (bus.ALUSrcA),
        .ALUSrcB      (bus.ALUSrcB),
        .ShiftSrc     (bus.ShiftSrc),
        .ZeroExt      (bus.ZeroExt),
        .IorD         (bus.IorD),
        .MemRead      (bus.MemRead),
        .MemWrite     (bus.MemWrite),
        .IRWrite      (bus.IRWrite),
        .RegWrite     (bus.RegWrite),
        .PCWrite      (bus.PCWrite),
        .RegDst       (bus.RegDst),
        .MemtoReg     (bus.MemtoReg),
        .PCSource     (bus.PCSource),
        .IllegalInstr (bus.IllegalInstr)
    );

    typedef struct packed {
        logic [3:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       shift;
        logic       zext;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       pcw;
        logic       rdst;
        logic       m2r;
        logic [1:0] pcsrc;
        logic       ill;
    } obs_t;

    obs_t tr [0:8];
    int   tr_len;

    logic [5:0] legal_ops [0:10] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C,
                                     6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02};
    logic [5:0] legal_fns [0:6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (instruction-level) ----------------
    function automatic bit m_rfn(input logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};
    endfunction

    function automatic int m_len(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                             return m_rfn(fn) ? 4 : 2;
            6'h23:                             return 5;
            6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F: return 4;
            6'h04, 6'h05, 6'h02:               return 3;
            default:                           return 2;
        endcase
    endfunction

    // ALU opcode expected in the third cycle of the instruction.
    function automatic logic [3:0] m_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20: return 4'd3;
                6'h22: return 4'd4;
                6'h24: return 4'd0;
                6'h25: return 4'd1;
                6'h27: return 4'd2;
                6'h00: return 4'd5;
                6'h02: return 4'd6;
                default: return 4'd3;
            endcase
        end
        case (op)
            6'h0C:        return 4'd0;
            6'h0D:        return 4'd1;
            6'h0F:        return 4'd7;
            6'h04, 6'h05: return 4'd4;
            default:      return 4'd3;
        endcase
    endfunction

    function automatic int m_rw(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return m_rfn(fn) ? 1 : 0;
        return (op inside {6'h23, 6'h08, 6'h0C, 6'h0D, 6'h0F}) ? 1 : 0;
    endfunction

    function automatic int m_pcw(input logic [5:0] op, input logic z);
        if (op == 6'h02) return 1;
        if (op == 6'h04) return z ? 1 : 0;
        if (op == 6'h05) return z ? 0 : 1;
        return 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic capture(output obs_t o);
        o.aluop = bus.ALUOperation; o.srca = bus.ALUSrcA;  o.srcb  = bus.ALUSrcB;
        o.shift = bus.ShiftSrc;     o.zext = bus.ZeroExt;  o.iord  = bus.IorD;
        o.mr    = bus.MemRead;      o.mw   = bus.MemWrite; o.irw   = bus.IRWrite;
        o.rw    = bus.RegWrite;     o.pcw  = bus.PCWrite;  o.rdst  = bus.RegDst;
        o.m2r   = bus.MemtoReg;     o.pcsrc = bus.PCSource; o.ill  = bus.IllegalInstr;
    endtask

    // Starting in a FETCH cycle, present one instruction and record every cycle up to
    // the next FETCH. Op/Funct are scrambled in cycles where they must be ignored.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        obs_t o;
        bus.Op = op; bus.Funct = fn; bus.Zero = z;
        #1;
        capture(o);
        tr[0]  = o;
        tr_len = -1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k >= 3) begin
                bus.Op    = 6'($urandom);
                bus.Funct = 6'($urandom);
            end
            #1;
            capture(o);
            tr[k] = o;
            if (o.irw && o.mr && !o.iord) begin
                tr_len = k;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; bus.Op = 6'h3F; bus.Funct = 6'h00; bus.Zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.Op = 6'($urandom);
            #1;
            checks++;
            if ({bus.PCWrite, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.IllegalInstr} !== 6'b0 ||
                {bus.ALUSrcA, bus.ALUSrcB, bus.ShiftSrc, bus.ZeroExt, bus.IorD, bus.RegDst, bus.MemtoReg, bus.PCSource} !== 10'b0 ||
                bus.ALUOperation !== 4'b0011) begin
                errors++;
                $display("FAIL reset_quiet cyc%0d: strobes=%b sels=%b alu=%b, required 0/0/0011", i,
                         {bus.PCWrite, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.IllegalInstr},
                         {bus.ALUSrcA, bus.ALUSrcB, bus.ShiftSrc, bus.ZeroExt, bus.IorD, bus.RegDst, bus.MemtoReg, bus.PCSource},
                         bus.ALUOperation);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.MemRead, bus.IRWrite, bus.PCWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOperation, bus.RegWrite, bus.MemWrite}
            !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0011, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL first_fetch: got mr/irw/pcw/iord/srca/srcb/pcsrc/alu/rw/mw=%b, required 1110001000011 00",
                     {bus.MemRead, bus.IRWrite, bus.PCWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOperation, bus.RegWrite, bus.MemWrite});
        end
    endtask

    task automatic test_rtype_add();
        run_instr(6'h00, 6'h20, 1'($urandom));
        checks++;
        if (tr_len !== 4) begin errors++; $display("FAIL add_latency: got %0d, required 4", tr_len); end
        checks++;
        if ({tr[1].srca, tr[1].srcb, tr[1].ill} !== 4'b0110) begin
            errors++; $display("FAIL add_decode: srca/srcb/ill=%b, required 0110", {tr[1].srca, tr[1].srcb, tr[1].ill});
        end
        checks++;
        if ({tr[2].aluop, tr[2].srca, tr[2].srcb, tr[2].shift} !== 8'b0011_1_00_0) begin
            errors++; $display("FAIL add_exec: alu/srca/srcb/shift=%b, required 00111000", {tr[2].aluop, tr[2].srca, tr[2].srcb, tr[2].shift});
        end
        checks++;
        if ({tr[3].rw, tr[3].rdst, tr[3].m2r} !== 3'b110) begin
            errors++; $display("FAIL add_rwb: rw/rdst/m2r=%b, required 110", {tr[3].rw, tr[3].rdst, tr[3].m2r});
        end
    endtask

    task automatic test_lw();
        logic any_mw;
        run_instr(6'h23, 6'h15, 1'($urandom));
        checks++;
        if (tr_len !== 5) begin errors++; $display("FAIL lw_latency: got %0d, required 5", tr_len); end
        checks++;
        if ({tr[2].srca, tr[2].srcb, tr[2].zext, tr[2].aluop} !== 8'b1_10_0_0011) begin
            errors++; $display("FAIL lw_memadr: srca/srcb/zext/alu=%b, required 11000011", {tr[2].srca, tr[2].srcb, tr[2].zext, tr[2].aluop});
        end
        checks++;
        if ({tr[3].iord, tr[3].mr, tr[3].rw} !== 3'b110) begin
            errors++; $display("FAIL lw_memrd: iord/mr/rw=%b, required 110", {tr[3].iord, tr[3].mr, tr[3].rw});
        end
        checks++;
        if ({tr[4].m2r, tr[4].rw, tr[4].rdst} !== 3'b110) begin
            errors++; $display("FAIL lw_memwb: m2r/rw/rdst=%b, required 110", {tr[4].m2r, tr[4].rw, tr[4].rdst});
        end
        any_mw = 1'b0;
        for (int k = 0; k <= 5; k++) any_mw = any_mw | tr[k].mw;
        checks++;
        if (any_mw !== 1'b0) begin errors++; $display("FAIL lw_no_memwrite: MemWrite seen=%b, required 0", any_mw); end
    endtask

    task automatic test_branch_jump();
        run_instr(6'h04, 6'h00, 1'b1);
        checks++;
        if ({tr_len == 3, tr[2].pcw, tr[2].pcsrc, tr[2].aluop, tr[2].srca} !== 9'b1_1_01_0100_1) begin
            errors++; $display("FAIL beq_taken: len=%0d pcw=%b pcsrc=%b alu=%b srca=%b, required 3/1/01/0100/1",
                               tr_len, tr[2].pcw, tr[2].pcsrc, tr[2].aluop, tr[2].srca);
        end
        run_instr(6'h05, 6'h00, 1'b1);
        checks++;
        if ({tr_len == 3, tr[2].pcw} !== 2'b10) begin
            errors++; $display("FAIL bne_not_taken: len=%0d pcw=%b, required 3/0", tr_len, tr[2].pcw);
        end
        run_instr(6'h05, 6'h00, 1'b0);
        checks++;
        if (tr[2].pcw !== 1'b1) begin errors++; $display("FAIL bne_taken: pcw=%b, required 1", tr[2].pcw); end
        run_instr(6'h02, 6'h11, 1'b0);
        checks++;
        if ({tr_len == 3, tr[2].pcw, tr[2].pcsrc} !== 4'b1_1_10) begin
            errors++; $display("FAIL jump: len=%0d pcw=%b pcsrc=%b, required 3/1/10", tr_len, tr[2].pcw, tr[2].pcsrc);
        end
    endtask

    task automatic test_shift_imm();
        run_instr(6'h00, 6'h00, 1'b0);
        checks++;
        if ({tr[2].aluop, tr[2].shift} !== 5'b0101_1) begin
            errors++; $display("FAIL sll: alu=%b shift=%b, required 0101/1", tr[2].aluop, tr[2].shift);
        end
        run_instr(6'h0D, 6'h3A, 1'b0);
        checks++;
        if ({tr[2].aluop, tr[2].zext, tr[2].srcb, tr[3].rw, tr[3].rdst} !== 9'b0001_1_10_1_0) begin
            errors++; $display("FAIL ori: alu=%b zext=%b srcb=%b iwb rw=%b rdst=%b, required 0001/1/10/1/0",
                               tr[2].aluop, tr[2].zext, tr[2].srcb, tr[3].rw, tr[3].rdst);
        end
        run_instr(6'h0F, 6'h00, 1'b0);
        checks++;
        if (tr[2].aluop !== 4'b0111) begin errors++; $display("FAIL lui: alu=%b, required 0111", tr[2].aluop); end
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h20, 1'b0);
        checks++;
        if ({tr_len == 2, tr[0].ill, tr[1].ill, tr[2].ill, tr[1].rw | tr[1].mw} !== 5'b1_0_1_0_0) begin
            errors++; $display("FAIL illegal_op: len=%0d ill=%b%b%b rw|mw=%b, required 2/010/0",
                               tr_len, tr[0].ill, tr[1].ill, tr[2].ill, tr[1].rw | tr[1].mw);
        end
        run_instr(6'h00, 6'h3F, 1'b0);
        checks++;
        if ({tr_len == 2, tr[1].ill} !== 2'b11) begin
            errors++; $display("FAIL illegal_funct: len=%0d ill=%b, required 2/1", tr_len, tr[1].ill);
        end
    endtask

    task automatic test_reset_mid();
        bus.Op = 6'h2B; bus.Funct = 6'h00; bus.Zero = 1'b0;
        #1;
        cyc(); cyc(); cyc();
        #1;
        checks++;
        if ({bus.MemWrite, bus.IorD} !== 2'b11) begin
            errors++; $display("FAIL sw_memwr: mw/iord=%b, required 11", {bus.MemWrite, bus.IorD});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.MemWrite, bus.IorD, bus.PCWrite} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_memwr: mw/iord/pcw=%b, required 000", {bus.MemWrite, bus.IorD, bus.PCWrite});
        end
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.IRWrite, bus.MemRead, bus.IorD, bus.MemWrite} !== 4'b1100) begin
            errors++; $display("FAIL reset_mid_fetch: irw/mr/iord/mw=%b, required 1100", {bus.IRWrite, bus.MemRead, bus.IorD, bus.MemWrite});
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] op, fn;
        logic       z;
        int         rw, mw, pcw, ill;
        for (int n = 0; n < 80; n++) begin
            int s_op, s_fn;
            s_op = int'($urandom_range(0, 11));
            s_fn = int'($urandom_range(0, 7));
            op = (s_op == 11) ? 6'($urandom) : legal_ops[s_op];
            fn = (s_fn == 7) ? 6'($urandom) : legal_fns[s_fn];
            z  = 1'($urandom);
            run_instr(op, fn, z);
            rw = 0; mw = 0; pcw = 0; ill = 0;
            for (int k = 1; k < tr_len; k++) begin
                rw  += int'(tr[k].rw);
                mw  += int'(tr[k].mw);
                pcw += int'(tr[k].pcw);
                ill += int'(tr[k].ill);
            end
            checks++;
            if (tr_len !== m_len(op, fn) || tr[2].aluop !== m_alu(op, fn)) begin
                errors++; $display("FAIL rand%0d op=%h fn=%h: len=%0d alu=%b, required len=%0d alu=%b",
                                   n, op, fn, tr_len, tr[2].aluop, m_len(op, fn), m_alu(op, fn));
            end
            checks++;
            if (rw !== m_rw(op, fn) || mw !== ((op == 6'h2B) ? 1 : 0) || pcw !== m_pcw(op, z) ||
                ill !== ((m_len(op, fn) == 2) ? 1 : 0) ||
                tr[2].zext !== (op == 6'h0C || op == 6'h0D) ||
                tr[2].shift !== (op == 6'h00 && (fn == 6'h00 || fn == 6'h02))) begin
                errors++; $display("FAIL rand_fx%0d op=%h fn=%h z=%b: rw=%0d mw=%0d pcw=%0d ill=%0d zext=%b shift=%b, required rw=%0d mw=%0d pcw=%0d",
                                   n, op, fn, z, rw, mw, pcw, ill, tr[2].zext, tr[2].shift,
                                   m_rw(op, fn), (op == 6'h2B) ? 1 : 0, m_pcw(op, z));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;
        test_reset();
        test_rtype_add();
        test_lw();
        test_branch_jump();
        test_shift_imm();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have one parameter: STATE_WIDTH, default 4, width of the state register.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  6  instruction [31:26] from IR
- Funct  in  6  instruction [5:0] from IR
- Zero  in  1  ALU zero flag
- ALUOperation  out  4  ALU opcode: AND=0000, OR=0001, NOR=0010, ADD=0011, SUB=0100, SLL=0101, SRL=0110, LUI=0111
- ALUSrcA  out  1  0=PC, 1=reg A
- ALUSrcB  out  2  00=reg B, 01=const 4, 10=ext imm, 11=sext imm<<2
- ShiftSrc  out  1  1=route reg B (rt) onto ALU A port (sll/srl)
- ZeroExt  out  1  1=zero-extend imm (andi/ori), 0=sign-extend
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead / MemWrite / IRWrite / RegWrite / PCWrite  out  1 each  strobes
- RegDst  out  1  0=rt, 1=rd
- MemtoReg  out  1  0=ALUOut, 1=MDR
- PCSource  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- IllegalInstr  out  1  one-cycle pulse on unsupported Op/Funct
REQ-003 The clock port SHALL be named clk and the reset port reset; reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL be an FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP; all outputs SHALL be Moore-decoded from state, except PCWrite in BRANCH and IllegalInstr in DECODE.
REQ-005 Unlisted outputs SHALL be 0 in every state; ALUOperation SHALL default to ADD.
REQ-006 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCWrite=1; next DECODE.
REQ-007 DECODE: ALUSrcA=0, ALUSrcB=11, ADD; next by Op: 0x00 EXEC_R; 0x23/0x2B MEMADR; 0x08/0x0C/0x0D/0x0F EXEC_I; 0x04/0x05 BRANCH; 0x02 JUMP; else FETCH with IllegalInstr=1.
REQ-008 Op=0x00 with Funct not in {0x20,0x22,0x24,0x25,0x27,0x00,0x02} SHALL be illegal: DECODE->FETCH, IllegalInstr=1.
REQ-009 MEMADR: ALUSrcA=1, ALUSrcB=10, ZeroExt=0, ADD; next MEMRD (lw) or MEMWR (sw).
REQ-010 MEMRD: IorD=1, MemRead=1; next MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-011 MEMWR: IorD=1, MemWrite=1; next FETCH.
REQ-012 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOperation from Funct (20 ADD, 22 SUB, 24 AND, 25 OR, 27 NOR, 00 SLL, 02 SRL), ShiftSrc=1 only for SLL/SRL; next RWB.
REQ-013 RWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-014 EXEC_I: ALUSrcA=1, ALUSrcB=10; addi ADD/ZeroExt=0, andi AND/ZeroExt=1, ori OR/ZeroExt=1, lui LUI; next IWB. IWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-015 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01; PCWrite=Zero (beq) or ~Zero (bne), combinational same cycle; next FETCH.
REQ-016 JUMP: PCSource=10, PCWrite=1; next FETCH.
REQ-017 Latency (cycles, FETCH to FETCH): lw 5; sw, R-type, I-type 4; beq/bne, j 3; illegal 2.
REQ-018 Op/Funct SHALL be sampled only in DECODE/EXEC_R/EXEC_I/MEMADR/BRANCH; changes elsewhere SHALL have no effect.
REQ-019 Unreachable state encodings SHALL transition to FETCH with all strobes 0.

Reset
REQ-020 reset high at a rising edge SHALL load FETCH regardless of current state, including mid-instruction.
REQ-021 While reset is high, PCWrite, MemRead, MemWrite, IRWrite, RegWrite, IllegalInstr SHALL be 0; mux selects SHALL be 0, ALUOperation ADD.
REQ-022 First cycle after reset deasserts SHALL be FETCH with FETCH outputs.

Structure
REQ-023 A shared package mips_ctrl_pkg SHALL hold ALUOperation codes, Op/Funct constants and state encodings; the existing ALU SHALL use the same ALUOperation codes.
REQ-024 Funct/Op-to-ALUOperation mapping SHALL be one combinational sub-module, alu_op_decoder.

Verification
REQ-025 reset 3 cycles, then Op=0x00/Funct=0x20 -> FETCH,DECODE,EXEC_R(ADD,SrcB=00),RWB(RegWrite=1,RegDst=1), FETCH cycle 5.
REQ-026 Op=0x23 (lw) -> MEMADR,MEMRD(IorD=1),MEMWB(MemtoReg=1); 5 cycles; MemWrite never 1.
REQ-027 Op=0x04 with Zero=1 -> PCWrite=1, PCSource=01 in BRANCH; Op=0x05 with Zero=1 -> PCWrite=0.
REQ-028 Op=0x00/Funct=0x00 (sll) -> ALUOperation=0101, ShiftSrc=1; Op=0x0D (ori) -> OR, ZeroExt=1.
REQ-029 Op=0x3F -> IllegalInstr=1 for exactly one cycle in DECODE, FETCH next, no RegWrite/MemWrite.
REQ-030 reset asserted during MEMWR -> MemWrite=0 that cycle, FETCH next.
